// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 VGA timing constants and counter width.
// Shared by the sync generator and its per-axis counters.
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL =
    DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL =
    DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam logic DEF_SYNC_POL = 1'b0;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: position counter plus registered sync/active decode.
// Decode uses the next count so it lines up with count in the same cycle.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int   ACTIVE = DEF_H_ACTIVE,
  parameter int   FP     = DEF_H_FP,
  parameter int   SYNC   = DEF_H_SYNC,
  parameter int   BP     = DEF_H_BP,
  parameter logic POL    = DEF_SYNC_POL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wrap_in,
  output logic [CNT_W-1:0] count,
  output logic             sync,
  output logic             active,
  output logic             wrap_out
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] S_LO = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] S_HI = CNT_W'(ACTIVE + FP + SYNC);
  localparam logic [CNT_W-1:0] ACT  = CNT_W'(ACTIVE);

  logic [CNT_W-1:0] nxt;

  assign wrap_out = (count == LAST);

  always_comb begin
    nxt = count;
    if (en && wrap_in)
      nxt = wrap_out ? '0 : count + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      sync   <= ~POL;
      active <= 1'b1;
    end else begin
      count  <= nxt;
      sync   <= (nxt >= S_LO && nxt < S_HI) ? POL : ~POL;
      active <= (nxt < ACT);
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator advanced by a pixel-enable strobe.
// Define VGA_FRAME_COUNT_EN to add a 16-bit frame_count output.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = DEF_SYNC_POL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_en,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             line_tick,
  output logic             frame_tick
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [15:0]      frame_count
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_sync_gen: H_TOTAL/V_TOTAL exceed 1024");
  end

  logic h_wrap;
  logic v_wrap;
  logic h_act;
  logic v_act;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC),
    .BP(H_BP), .POL(SYNC_POL)
  ) u_h (
    .clk(clk), .rst(rst),
    .en(pix_en), .wrap_in(1'b1),
    .count(pixel_x), .sync(hsync),
    .active(h_act), .wrap_out(h_wrap)
  );

  // Vertical axis steps only on the strobe that wraps the line.
  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC),
    .BP(V_BP), .POL(SYNC_POL)
  ) u_v (
    .clk(clk), .rst(rst),
    .en(pix_en), .wrap_in(h_wrap),
    .count(pixel_y), .sync(vsync),
    .active(v_act), .wrap_out(v_wrap)
  );

  assign video_on = h_act & v_act;

  always_ff @(posedge clk) begin
    if (rst) begin
      line_tick  <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      line_tick  <= pix_en & h_wrap;
      frame_tick <= pix_en & h_wrap & v_wrap;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      frame_count <= '0;
    else if (pix_en && h_wrap && v_wrap)
      frame_count <= frame_count + 16'd1;
  end
`endif

endmodule
